// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM built-in self-test: sequencer states,
// default bus widths and the pattern LFSR feedback taps.
package psram_pkg;

   localparam int PSRAM_ADDR_W = 23;
   localparam int PSRAM_DATA_W = 8;

   // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      RWAIT,
      FIN
   } bist_state_t;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/psram_bist_pattern.sv
// Test pattern generator for the PSRAM BIST.
// Default build: pattern = idx[7:0] ^ SEED (combinational).
// PSRAM_BIST_LFSR_EN: pattern is an 8-bit Galois LFSR seeded with SEED on
// load and stepped on advance; load wins when both are asserted.
module psram_bist_pattern
   import psram_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       sys_clk,
   input  logic       sys_reset,
   input  logic       load,
   input  logic       advance,
   input  logic [7:0] idx,
   output logic [7:0] pattern
);

`ifdef PSRAM_BIST_LFSR_EN
   logic [7:0] lfsr;
   logic       unused_idx;

   assign unused_idx = ^idx;

   // LFSR state: reload with the seed at each pass start, step per byte
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         lfsr <= SEED;
      end else if (load) begin
         lfsr <= SEED;
      end else if (advance) begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   assign pattern = lfsr;
`else
   logic unused_ctl;

   assign unused_ctl = ^{sys_clk, sys_reset, load, advance};

   // Index-derived pattern needs no state
   always_comb begin
      pattern = idx ^ SEED;
   end
`endif

endmodule

// File: rtl/psram_bist.sv
// PSRAM built-in self-test sequencer. Writes a pattern over a window of
// NUM_WORDS bytes starting at START_ADDR, reads it back one read at a time,
// and reports pass/fail, an error count and the first failing address.
// Optional macro PSRAM_BIST_LFSR_EN selects the LFSR pattern source.
//
// state | meaning
// IDLE  | waiting for start; results from the last run held
// WR    | issuing write commands, one per accepted cycle
// RD    | issuing one read command
// RWAIT | waiting for read data or timeout, then compare
// FIN   | one-cycle completion, results published
module psram_bist
   import psram_pkg::*;
#(
   parameter int                ADDR_W     = PSRAM_ADDR_W,
   parameter int                DATA_W     = PSRAM_DATA_W,
   parameter int                NUM_WORDS  = 256,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter logic [7:0]        SEED       = 8'hA5,
   parameter int                RD_TIMEOUT = 64
) (
   input  logic              sys_clk,
   input  logic              sys_reset,
   input  logic              start,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_we,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [DATA_W-1:0] cmd_wdata,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
   localparam int                TMR_W    = $clog2(RD_TIMEOUT + 1);
   localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(RD_TIMEOUT - 1);

   bist_state_t       state;
   bist_state_t       state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [TMR_W-1:0]  tmr;
   logic [15:0]       err_q;
   logic [ADDR_W-1:0] first_q;
   logic              done_q;
   logic              pass_q;
   logic [7:0]        pattern;

   logic run_start;
   logic wr_acc;
   logic rd_acc;
   logic rd_hit;
   logic rd_tmo;
   logic rd_done;
   logic is_last;
   logic err_evt;

   assign run_start = (state == IDLE) && start;
   assign wr_acc    = (state == WR) && cmd_ready;
   assign rd_acc    = (state == RD) && cmd_ready;
   assign rd_hit    = (state == RWAIT) && rd_valid;
   // Data arriving on the expiry cycle wins over the timeout
   assign rd_tmo    = (state == RWAIT) && !rd_valid && (tmr == '0);
   assign rd_done   = rd_hit || rd_tmo;
   assign is_last   = (idx == LAST_IDX);
   assign err_evt   = rd_tmo || (rd_hit && (rd_data != DATA_W'(pattern)));

   psram_bist_pattern #(
      .SEED (SEED)
   ) u_pattern (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .load      (run_start || (wr_acc && is_last)),
      .advance   (wr_acc || rd_done),
      .idx       (idx[7:0]),
      .pattern   (pattern)
   );

   // State register
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = WR;
         WR:      if (cmd_ready && is_last) state_nxt = RD;
         RD:      if (cmd_ready) state_nxt = RWAIT;
         RWAIT:   if (rd_done) state_nxt = is_last ? FIN : RD;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; cmd_valid also drops while reset is high
   always_comb begin
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      busy      = 1'b0;
      done      = done_q;
      pass      = pass_q;
      case (state)
         WR: begin
            cmd_valid = !sys_reset;
            cmd_we    = 1'b1;
            cmd_addr  = START_ADDR + idx;
            cmd_wdata = DATA_W'(pattern);
            busy      = 1'b1;
         end
         RD: begin
            cmd_valid = !sys_reset;
            cmd_addr  = START_ADDR + idx;
            busy      = 1'b1;
         end
         RWAIT: begin
            busy = 1'b1;
         end
         FIN: begin
            done = 1'b1;
            pass = (err_q == '0);
         end
         default: begin
         end
      endcase
   end

   assign err_count      = err_q;
   assign first_err_addr = first_q;

   // Byte index, read timeout down-counter and result registers
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         idx     <= '0;
         tmr     <= '0;
         err_q   <= '0;
         first_q <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         if (run_start) begin
            idx     <= '0;
            err_q   <= '0;
            first_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
         end
         if (wr_acc) begin
            idx <= is_last ? '0 : idx + ADDR_W'(1);
         end
         if (rd_done) begin
            idx <= idx + ADDR_W'(1);
         end
         if (rd_acc) begin
            tmr <= TMR_LOAD;
         end else if ((state == RWAIT) && (tmr != '0)) begin
            tmr <= tmr - TMR_W'(1);
         end
         if (err_evt) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (err_q == '0) first_q <= START_ADDR + idx;
         end
         if (state == FIN) begin
            done_q <= 1'b1;
            pass_q <= (err_q == '0);
         end
      end
   end

endmodule

// File: tb/tb_psram_bist.sv
// Directed testbench for psram_bist: two instances (window at 0, and a window
// wrapping the top of memory) each driven by a small PSRAM controller model.
module tb_psram_bist;

   localparam int AW  = 23;
   localparam int DW  = 8;
   localparam int NW  = 4;
   localparam int TMO = 64;

   logic sys_clk   = 1'b0;
   logic sys_reset = 1'b1;

   always #5 sys_clk = ~sys_clk;

   logic          a_start = 1'b0;
   logic          a_cmd_valid, a_cmd_we, a_busy, a_done, a_pass;
   logic          a_cmd_ready = 1'b1;
   logic          a_rd_valid  = 1'b0;
   logic [DW-1:0] a_rd_data   = '0;
   logic [AW-1:0] a_cmd_addr, a_first;
   logic [DW-1:0] a_cmd_wdata;
   logic [15:0]   a_err;

   logic          b_start = 1'b0;
   logic          b_cmd_valid, b_cmd_we, b_busy, b_done, b_pass;
   logic          b_cmd_ready = 1'b1;
   logic          b_rd_valid  = 1'b0;
   logic [DW-1:0] b_rd_data   = '0;
   logic [AW-1:0] b_cmd_addr, b_first;
   logic [DW-1:0] b_cmd_wdata;
   logic [15:0]   b_err;

   psram_bist #(
      .NUM_WORDS (NW), .START_ADDR (23'h000000), .SEED (8'hA5), .RD_TIMEOUT (TMO)
   ) dut (
      .sys_clk (sys_clk), .sys_reset (sys_reset), .start (a_start),
      .cmd_valid (a_cmd_valid), .cmd_ready (a_cmd_ready), .cmd_we (a_cmd_we),
      .cmd_addr (a_cmd_addr), .cmd_wdata (a_cmd_wdata),
      .rd_valid (a_rd_valid), .rd_data (a_rd_data),
      .busy (a_busy), .done (a_done), .pass (a_pass),
      .err_count (a_err), .first_err_addr (a_first)
   );

   psram_bist #(
      .NUM_WORDS (NW), .START_ADDR (23'h7FFFFE), .SEED (8'hA5), .RD_TIMEOUT (TMO)
   ) dut_wrap (
      .sys_clk (sys_clk), .sys_reset (sys_reset), .start (b_start),
      .cmd_valid (b_cmd_valid), .cmd_ready (b_cmd_ready), .cmd_we (b_cmd_we),
      .cmd_addr (b_cmd_addr), .cmd_wdata (b_cmd_wdata),
      .rd_valid (b_rd_valid), .rd_data (b_rd_data),
      .busy (b_busy), .done (b_done), .pass (b_pass),
      .err_count (b_err), .first_err_addr (b_first)
   );

   int checks = 0;
   int errors = 0;

   // Controller model state
   int            cyc          = 0;
   logic          stall_mode   = 1'b0;
   int            corrupt_addr = -1;
   int            drop_addr    = -1;
   logic [DW-1:0] mem_a [int];
   logic [DW-1:0] mem_b [int];
   logic          a_pend = 1'b0;
   logic [AW-1:0] a_pend_addr;
   int            a_lat;
   logic          b_pend = 1'b0;
   logic [AW-1:0] b_pend_addr;
   logic [AW-1:0] wr_addr_q [$];
   logic [DW-1:0] wr_data_q [$];
   int            wr_cyc_q  [$];
   logic [AW-1:0] rd_addr_q [$];
   int            rd_cyc_q  [$];
   logic [AW-1:0] bwr_addr_q [$];
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_wdata;
   logic          prev_we;
   int            stable_viol = 0;

   // Model runs at negedge: picks ready/read data for the next posedge and
   // logs the commands that posedge will accept.
   always @(negedge sys_clk) begin
      cyc++;
      if (prev_stall && a_cmd_valid &&
          (a_cmd_addr !== prev_addr || a_cmd_wdata !== prev_wdata || a_cmd_we !== prev_we))
         stable_viol++;

      a_cmd_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      a_rd_valid  = 1'b0;
      if (a_pend) begin
         if (a_lat > 0) begin
            a_lat--;
         end else begin
            a_pend = 1'b0;
            if (int'(a_pend_addr) != drop_addr) begin
               a_rd_valid = 1'b1;
               a_rd_data  = mem_a[int'(a_pend_addr)] ^
                            ((int'(a_pend_addr) == corrupt_addr) ? 8'h01 : 8'h00);
            end
         end
      end
      if (a_cmd_valid && a_cmd_ready) begin
         if (a_cmd_we) begin
            mem_a[int'(a_cmd_addr)] = a_cmd_wdata;
            wr_addr_q.push_back(a_cmd_addr);
            wr_data_q.push_back(a_cmd_wdata);
            wr_cyc_q.push_back(cyc);
         end else begin
            a_pend      = 1'b1;
            a_pend_addr = a_cmd_addr;
            a_lat       = 2;
            rd_addr_q.push_back(a_cmd_addr);
            rd_cyc_q.push_back(cyc);
         end
      end
      prev_stall = a_cmd_valid && !a_cmd_ready;
      prev_addr  = a_cmd_addr;
      prev_wdata = a_cmd_wdata;
      prev_we    = a_cmd_we;

      b_rd_valid = 1'b0;
      if (b_pend) begin
         b_pend     = 1'b0;
         b_rd_valid = 1'b1;
         b_rd_data  = mem_b[int'(b_pend_addr)];
      end
      if (b_cmd_valid && b_cmd_ready) begin
         if (b_cmd_we) begin
            mem_b[int'(b_cmd_addr)] = b_cmd_wdata;
            bwr_addr_q.push_back(b_cmd_addr);
         end else begin
            b_pend      = 1'b1;
            b_pend_addr = b_cmd_addr;
         end
      end
   end

   function automatic logic [7:0] exp_pat(input int i);
      logic [7:0] s;
`ifdef PSRAM_BIST_LFSR_EN
      s = 8'hA5;
      for (int k = 0; k < i; k++) s = {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
`else
      case (i)
         0:       s = 8'hA5;
         1:       s = 8'hA4;
         2:       s = 8'hA7;
         default: s = 8'hA6;
      endcase
`endif
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      rd_addr_q.delete();
      rd_cyc_q.delete();
   endtask

   task automatic pulse_start_a();
      @(negedge sys_clk);
      a_start = 1'b1;
      @(negedge sys_clk);
      a_start = 1'b0;
   endtask

   task automatic wait_done_a(input int budget, input string tag);
      int n = 0;
      while (!a_done && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      chk(tag, 32'(a_done), 32'd1);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'd4);
      for (int i = 0; i < NW; i++) begin
         chk({tag, "_wr_addr"}, 32'(wr_addr_q[i]), 32'(i));
         chk({tag, "_wr_data"}, 32'(wr_data_q[i]), 32'(exp_pat(i)));
      end
      chk({tag, "_rd_cnt"}, 32'(rd_addr_q.size()), 32'd4);
      for (int i = 0; i < NW; i++) chk({tag, "_rd_addr"}, 32'(rd_addr_q[i]), 32'(i));
   endtask

   initial begin
      repeat (3) @(negedge sys_clk);
      chk("rst_cmd_valid", 32'(a_cmd_valid), 32'd0);
      chk("rst_busy",      32'(a_busy),      32'd0);
      chk("rst_done",      32'(a_done),      32'd0);
      chk("rst_pass",      32'(a_pass),      32'd0);
      chk("rst_err",       32'(a_err),       32'd0);
      chk("rst_addr",      32'(a_cmd_addr),  32'd0);
      sys_reset = 1'b0;

      // Clean run; a second start mid-run must be ignored
      clear_logs();
      pulse_start_a();
      chk("t1_busy", 32'(a_busy), 32'd1);
      repeat (6) @(negedge sys_clk);
      a_start = 1'b1;
      @(negedge sys_clk);
      a_start = 1'b0;
      wait_done_a(300, "t1_done");
      check_writes("t1");
      chk("t1_wr_back2back", 32'(wr_cyc_q[3] - wr_cyc_q[0]), 32'd3);
      chk("t1_pass", 32'(a_pass), 32'd1);
      chk("t1_err",  32'(a_err),  32'd0);
      chk("t1_busy_end", 32'(a_busy), 32'd0);

      // Corrupted byte at address 2
      corrupt_addr = 2;
      clear_logs();
      pulse_start_a();
      chk("t2_done_cleared", 32'(a_done), 32'd0);
      wait_done_a(300, "t2_done");
      chk("t2_err",   32'(a_err),   32'd1);
      chk("t2_first", 32'(a_first), 32'd2);
      chk("t2_pass",  32'(a_pass),  32'd0);
      corrupt_addr = -1;

      // No data for address 1: read timeout
      drop_addr = 1;
      clear_logs();
      pulse_start_a();
      wait_done_a(600, "t3_done");
      chk("t3_rwait_len", 32'(rd_cyc_q[2] - rd_cyc_q[1] - 1), 32'(TMO));
      chk("t3_rd_cnt", 32'(rd_addr_q.size()), 32'd4);
      chk("t3_err",   32'(a_err),   32'd1);
      chk("t3_first", 32'(a_first), 32'd1);
      chk("t3_pass",  32'(a_pass),  32'd0);
      drop_addr = -1;

      // Random back-pressure
      stall_mode  = 1'b1;
      stable_viol = 0;
      clear_logs();
      pulse_start_a();
      wait_done_a(1000, "t4_done");
      stall_mode = 1'b0;
      check_writes("t4");
      chk("t4_stable", 32'(stable_viol), 32'd0);
      chk("t4_pass",   32'(a_pass),      32'd1);

      // Reset during the write phase
      pulse_start_a();
      chk("t5_in_wr", 32'(a_cmd_valid && a_cmd_we), 32'd1);
      sys_reset = 1'b1;
      @(negedge sys_clk);
      chk("t5_cmd_valid", 32'(a_cmd_valid), 32'd0);
      chk("t5_busy",      32'(a_busy),      32'd0);
      chk("t5_done",      32'(a_done),      32'd0);
      sys_reset = 1'b0;
      @(negedge sys_clk);
      clear_logs();
      pulse_start_a();
      wait_done_a(300, "t5_done_rerun");
      check_writes("t5");
      chk("t5_pass", 32'(a_pass), 32'd1);

      // Window wrapping the top of the address space
      bwr_addr_q.delete();
      @(negedge sys_clk);
      b_start = 1'b1;
      @(negedge sys_clk);
      b_start = 1'b0;
      for (int n = 0; n < 300 && !b_done; n++) @(negedge sys_clk);
      chk("t6_done", 32'(b_done), 32'd1);
      chk("t6_wr_cnt", 32'(bwr_addr_q.size()), 32'd4);
      chk("t6_addr0", 32'(bwr_addr_q[0]), 32'h7FFFFE);
      chk("t6_addr1", 32'(bwr_addr_q[1]), 32'h7FFFFF);
      chk("t6_addr2", 32'(bwr_addr_q[2]), 32'h000000);
      chk("t6_addr3", 32'(bwr_addr_q[3]), 32'h000001);
      chk("t6_pass",  32'(b_pass), 32'd1);
      chk("t6_err",   32'(b_err),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
